// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver (hh:mm) with anti-ghosting blank
// slots, per-frame input snapshot, leading-zero blanking and colon.
module seg7_scan_driver #(
    parameter int DWELL_CYC  = 1000,
    parameter int BLANK_CYC  = 50,
    parameter int ACTIVE_LOW = 0,
    parameter int BLANK_LZ   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] digits_i,
    input  logic        colon_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic        frame_o
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    // Pin polarity is folded into the register inputs so the pins stay pure flops.
    localparam logic [6:0] SEG_POL = (ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [3:0] AN_POL  = (ACTIVE_LOW != 0) ? 4'hf  : 4'h0;
    localparam logic       DP_POL  = (ACTIVE_LOW != 0) ? 1'b1  : 1'b0;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [1:0]     idx_r, idx_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [15:0]    snap_r;
    logic           snap_colon_r;
    logic           snap_load_s;
    logic [3:0]     nib_s;
    logic [6:0]     seg_r, seg_s;
    logic           dp_r, dp_s;
    logic [3:0]     an_r, an_s;
    logic           frame_r, frame_s;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // Next-state, counter and next-output logic; outputs follow the next state.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r + CW'(1);
        snap_load_s = 1'b0;
        frame_s     = 1'b0;
        seg_s       = 7'b0000000;
        dp_s        = 1'b0;
        an_s        = 4'b0000;
        nib_s       = 4'h0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_DRIVE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == DWELL_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = {CW{1'b0}};
                    idx_s   = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        snap_load_s = 1'b1;
                        frame_s     = 1'b1;
                    end else begin
                        snap_load_s = 1'b0;
                    end
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            default: begin
                state_s = ST_BLANK;
                idx_s   = 2'd0;
                cnt_s   = {CW{1'b0}};
            end
        endcase
        case (idx_s)
            2'd0:    nib_s = snap_r[3:0];
            2'd1:    nib_s = snap_r[7:4];
            2'd2:    nib_s = snap_r[11:8];
            2'd3:    nib_s = snap_r[15:12];
            default: nib_s = 4'h0;
        endcase
        if (state_s == ST_DRIVE) begin
            an_s = 4'b0001 << idx_s;
            dp_s = (idx_s == 2'd2) & snap_colon_r;
            if ((BLANK_LZ != 0) && (idx_s == 2'd3) && (nib_s == 4'h0)) begin
                seg_s = 7'b0000000;
            end else begin
                seg_s = dec7(nib_s);
            end
        end else begin
            an_s = 4'b0000;
        end
    end

    // State, snapshot and registered output update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_BLANK;
            idx_r        <= 2'd0;
            cnt_r        <= {CW{1'b0}};
            snap_r       <= digits_i;
            snap_colon_r <= colon_i;
            seg_r        <= SEG_POL;
            dp_r         <= DP_POL;
            an_r         <= AN_POL;
            frame_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            if (snap_load_s) begin
                snap_r       <= digits_i;
                snap_colon_r <= colon_i;
            end
            seg_r   <= seg_s ^ SEG_POL;
            dp_r    <= dp_s ^ DP_POL;
            an_r    <= an_s ^ AN_POL;
            frame_r <= frame_s;
        end
    end

    assign seg_o   = seg_r;
    assign dp_o    = dp_r;
    assign an_o    = an_r;
    assign frame_o = frame_r;

endmodule
